// File: rtl/mem_access_unit_pkg.sv
// +------------------------------------------------------------------+
// | mau_pkg: shared types, funct3 codes and legality helpers         |
// | for the memory access unit.                                      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package mau_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_STORE  = 3'd4,
    ST_RESP   = 3'd5
  } mau_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants have no meaning for stores.
  function automatic logic is_legal_f3(input logic [2:0] f3, input logic is_store);
    logic legal;
    legal = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~is_store;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// +------------------------------------------------------------------+
// | mem_access_unit_if: requester, response and memory bus signals.  |
// | master = the access unit, slave = requesters plus memory.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface mem_access_unit_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [2:0]  d_funct3;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        rsp_valid;
  logic        rsp_is_fetch;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] read_data;
  logic [31:0] instruction;

  modport master (
    input  if_req, if_pc, d_req, d_write, d_addr, d_funct3, d_wdata,
    input  read_data, instruction,
    output if_ready, d_ready, rsp_valid, rsp_is_fetch, rsp_data, rsp_err,
    output mem_read, mem_write, address, write_data, funct3
  );

  modport slave (
    output if_req, if_pc, d_req, d_write, d_addr, d_funct3, d_wdata,
    output read_data, instruction,
    input  if_ready, d_ready, rsp_valid, rsp_is_fetch, rsp_data, rsp_err,
    input  mem_read, mem_write, address, write_data, funct3
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
// +------------------------------------------------------------------+
// | load_align: selects the addressed byte/half of a memory word     |
// | and sign- or zero-extends it to 32 bits.                         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module load_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  f3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    result = word;
    case (f3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +------------------------------------------------------------------+
// | mem_access_unit: arbitrates fetch and load/store requests onto   |
// | the shared memory bus and returns one-cycle response strobes.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [2:0] RESET_FUNCT3 = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.master bus
);

  mau_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  f3_q, f3_d;
  logic        err_q, err_d;
  logic        fetch_q, fetch_d;
  logic [31:0] load_result;

  load_align u_load_align (
    .word   (bus.read_data),
    .offset (addr_q[1:0]),
    .f3     (f3_q),
    .result (load_result)
  );

  // Data port wins a tie so a pending load/store is never starved by fetch.
  assign bus.d_ready  = (state_q == ST_IDLE) & bus.d_req;
  assign bus.if_ready = (state_q == ST_IDLE) & bus.if_req & ~bus.d_req;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    f3_d    = f3_q;
    err_d   = err_q;
    fetch_d = fetch_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.d_req) begin
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          f3_d    = bus.d_funct3;
          data_d  = 32'h0;
          fetch_d = 1'b0;
          err_d   = 1'b0;
          if (!is_legal_f3(bus.d_funct3, bus.d_write) ||
              !is_aligned(bus.d_addr[1:0], bus.d_funct3)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (bus.d_write) begin
            state_d = ST_STORE;
          end else begin
            state_d = ST_LOAD_A;
          end
        end else if (bus.if_req) begin
          addr_d  = bus.if_pc;
          wdata_d = 32'h0;
          f3_d    = RESET_FUNCT3;
          data_d  = 32'h0;
          fetch_d = 1'b1;
          err_d   = (bus.if_pc[1:0] != 2'b00);
          state_d = (bus.if_pc[1:0] != 2'b00) ? ST_RESP : ST_FETCH;
        end
      end
      ST_FETCH: begin
        data_d  = bus.instruction;
        state_d = ST_RESP;
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
        data_d  = load_result;
        state_d = ST_RESP;
      end
      ST_STORE:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      f3_q    <= RESET_FUNCT3;
      err_q   <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      fetch_q <= fetch_d;
    end
  end

  // Bus outputs decode only registered state, so rst clears them immediately.
  always_comb begin
    bus.address      = 32'h0;
    bus.write_data   = 32'h0;
    bus.funct3       = RESET_FUNCT3;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_data     = 32'h0;
    bus.rsp_err      = 1'b0;
    bus.rsp_is_fetch = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.address = addr_q;
      end
      ST_LOAD_A, ST_LOAD_B: begin
        bus.address  = addr_q;
        bus.funct3   = f3_q;
        bus.mem_read = 1'b1;
      end
      ST_STORE: begin
        bus.address    = addr_q;
        bus.write_data = wdata_q;
        bus.funct3     = f3_q;
        bus.mem_write  = 1'b1;
      end
      ST_RESP: begin
        bus.rsp_valid    = 1'b1;
        bus.rsp_data     = data_q;
        bus.rsp_err      = err_q;
        bus.rsp_is_fetch = fetch_q;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +------------------------------------------------------------------+
// | tb_mem_access_unit: memory/peripheral model plus a byte-level    |
// | reference model driving directed and random transactions.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;

  localparam logic [2:0] RST_F3 = 3'b010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.RESET_FUNCT3(RST_F3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int both_ready_cycles = 0;

  logic [31:0] mem_words [0:2047];
  logic [7:0]  ref_mem   [0:8191];
  logic [31:0] millis_val;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus-side memory: word array, registered read, combinational instruction.
  function automatic logic [31:0] bus_lookup(input logic [31:0] a);
    if (a < 32'h2000) return mem_words[a[12:2]];
    if (a[31:2] == 30'h3FFFFFFE) return millis_val;
    return 32'h0;
  endfunction

  always_comb bus.instruction = bus_lookup(bus.address);

  always @(posedge clk) begin
    if (bus.mem_read) bus.read_data <= bus_lookup(bus.address);
    if (bus.mem_write && bus.address < 32'h2000) begin
      case (bus.funct3[1:0])
        2'b00:   mem_words[bus.address[12:2]][8*bus.address[1:0] +: 8] <= bus.write_data[7:0];
        2'b01:   mem_words[bus.address[12:2]][16*bus.address[1] +: 16] <= bus.write_data[15:0];
        default: mem_words[bus.address[12:2]] <= bus.write_data;
      endcase
    end
  end

  always @(negedge clk) if (bus.if_ready && bus.d_ready) both_ready_cycles++;

  // Reference model: byte-addressed memory and the architectural load/store rules.
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input bit wr, input logic [31:0] a, input logic [2:0] f3);
    bit legal;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
    return !legal || ((a % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    if (a < 32'h2000) begin
      base = int'(a[12:0]) & ~3;
      return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    end
    if ((a & ~32'h3) == 32'hFFFFFFF8) return millis_val;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] sh;
    sh = ref_word(a) >> (8 * int'(a[1:0]));
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd4:    return {24'h0, sh[7:0]};
      3'd1:    return 32'($signed(sh[15:0]));
      3'd5:    return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < acc_size(f3); i++)
      if (a + i < 32'h2000) ref_mem[int'(a[12:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic run_txn(input bit fetch, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, input bit hold_fetch, input logic [31:0] fpc,
                         input string tag, output logic [31:0] got);
    int lat, nrd, nwr, waitc, exp_lat;
    bit exp_err;
    logic [31:0] exp_data, st_addr, st_wd;
    logic [2:0] st_f3;
    st_addr = 32'h0; st_wd = 32'h0; st_f3 = 3'h0; got = 32'h0;
    if (fetch) begin
      exp_err  = (a[1:0] != 2'b00);
      exp_data = exp_err ? 32'h0 : ref_word(a);
      exp_lat  = exp_err ? 1 : 2;
    end else begin
      exp_err  = ref_err(wr, a, f3);
      exp_data = (exp_err || wr) ? 32'h0 : ref_load(a, f3);
      exp_lat  = exp_err ? 1 : (wr ? 2 : 3);
    end
    @(negedge clk);
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_pc = a;
    end else begin
      bus.d_req = 1'b1; bus.d_write = wr; bus.d_addr = a; bus.d_funct3 = f3; bus.d_wdata = wd;
      if (hold_fetch) begin bus.if_req = 1'b1; bus.if_pc = fpc; end
    end
    #1;
    waitc = 0;
    while (!(fetch ? bus.if_ready : bus.d_ready) && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    check_eq({tag, " accept_wait"}, waitc, 0);
    if (waitc >= 20) begin
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      return;
    end
    if (hold_fetch) check_eq({tag, " if_ready_while_data"}, {31'h0, bus.if_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    if (fetch) bus.if_req = 1'b0; else bus.d_req = 1'b0;
    lat = 1; nrd = 0; nwr = 0;
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.mem_read) nrd++;
      if (bus.mem_write) begin
        nwr++; st_addr = bus.address; st_f3 = bus.funct3; st_wd = bus.write_data;
      end
      @(negedge clk); lat++;
    end
    got = bus.rsp_data;
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " rsp_data"}, bus.rsp_data, exp_data);
    check_eq({tag, " rsp_err"}, {31'h0, bus.rsp_err}, {31'h0, exp_err});
    check_eq({tag, " rsp_is_fetch"}, {31'h0, bus.rsp_is_fetch}, {31'h0, fetch});
    check_eq({tag, " mem_read_cycles"}, nrd, (!fetch && !wr && !exp_err) ? 2 : 0);
    check_eq({tag, " mem_write_cycles"}, nwr, (!fetch && wr && !exp_err) ? 1 : 0);
    if (!fetch && wr && !exp_err) begin
      check_eq({tag, " st_address"}, st_addr, a);
      check_eq({tag, " st_funct3"}, {29'h0, st_f3}, {29'h0, f3});
      check_eq({tag, " st_wdata"}, st_wd, wd);
      ref_store(a, f3, wd);
    end
  endtask

  task automatic reset_mid(input bit in_store, input logic [31:0] a, input logic [31:0] wd, input string tag);
    int spurious;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_write = in_store; bus.d_addr = a; bus.d_funct3 = 3'b010; bus.d_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.d_req = 1'b0;
    if (!in_store) @(negedge clk);
    check_eq({tag, " strobe_before_rst"}, {31'h0, in_store ? bus.mem_write : bus.mem_read}, 1);
    #1 rst = 1'b1;
    #1;
    check_eq({tag, " rst mem_read"}, {31'h0, bus.mem_read}, 0);
    check_eq({tag, " rst mem_write"}, {31'h0, bus.mem_write}, 0);
    check_eq({tag, " rst address"}, bus.address, 0);
    check_eq({tag, " rst write_data"}, bus.write_data, 0);
    check_eq({tag, " rst funct3"}, {29'h0, bus.funct3}, {29'h0, RST_F3});
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) spurious++;
    end
    check_eq({tag, " rsp_after_rst"}, spurious, 0);
  endtask

  initial begin
    logic [31:0] got, a, wd;
    logic [2:0]  f3;
    int kind;
    bus.if_req = 1'b0; bus.if_pc = 32'h0; bus.d_req = 1'b0; bus.d_write = 1'b0;
    bus.d_addr = 32'h0; bus.d_funct3 = 3'h0; bus.d_wdata = 32'h0; bus.read_data = 32'h0;
    millis_val = $urandom;
    for (int i = 0; i < 2048; i++) mem_words[i] = $urandom;
    mem_words[4] = 32'h00A00093;
    mem_words[8] = 32'h80FF7F01;
    for (int i = 0; i < 2048; i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = mem_words[i][8*b +: 8];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset rsp_valid", {31'h0, bus.rsp_valid}, 0);
    check_eq("reset mem_read", {31'h0, bus.mem_read}, 0);
    check_eq("reset mem_write", {31'h0, bus.mem_write}, 0);
    check_eq("reset address", bus.address, 0);
    check_eq("reset funct3", {29'h0, bus.funct3}, {29'h0, RST_F3});
    rst = 1'b0;

    run_txn(1, 0, 32'h10, 3'd0, 0, 0, 0, "fetch 0x10", got);
    check_eq("fetch 0x10 value", got, 32'h00A00093);
    run_txn(0, 0, 32'h23, 3'd0, 0, 0, 0, "lb 0x23", got);
    check_eq("lb 0x23 value", got, 32'hFFFFFF80);
    run_txn(0, 0, 32'h23, 3'd4, 0, 0, 0, "lbu 0x23", got);
    check_eq("lbu 0x23 value", got, 32'h00000080);
    run_txn(0, 0, 32'h22, 3'd1, 0, 0, 0, "lh 0x22", got);
    check_eq("lh 0x22 value", got, 32'hFFFF80FF);
    run_txn(0, 0, 32'h20, 3'd5, 0, 0, 0, "lhu 0x20", got);
    check_eq("lhu 0x20 value", got, 32'h00007F01);
    run_txn(0, 1, 32'h102, 3'd1, 32'h0000BEEF, 0, 0, "sh 0x102", got);
    run_txn(0, 0, 32'h100, 3'd2, 0, 0, 0, "lw 0x100", got);
    check_eq("lw 0x100 upper", {16'h0, got[31:16]}, 32'h0000BEEF);
    run_txn(0, 0, 32'h101, 3'd2, 0, 0, 0, "lw misaligned", got);
    run_txn(0, 1, 32'h40, 3'd4, 32'h12345678, 0, 0, "store f3=100", got);
    run_txn(1, 0, 32'h12, 3'd0, 0, 0, 0, "fetch misaligned", got);
    run_txn(0, 0, 32'h24, 3'd2, 0, 1, 32'h10, "simul data", got);
    run_txn(1, 0, 32'h10, 3'd0, 0, 0, 0, "simul fetch", got);

    reset_mid(0, 32'h20, 0, "rst in LOAD_B");
    run_txn(0, 0, 32'h20, 3'd2, 0, 0, 0, "lw after rst", got);
    reset_mid(1, 32'h200, 32'hDEADBEEF, "rst in STORE");
    run_txn(0, 0, 32'h200, 3'd2, 0, 0, 0, "lw no partial store", got);
    run_txn(0, 0, 32'hFFFFFFF8, 3'd2, 0, 0, 0, "millis lw", got);
    check_eq("millis value", got, millis_val);
    run_txn(0, 0, 32'hFFFFFFF9, 3'd4, 0, 0, 0, "millis lbu", got);
    run_txn(0, 0, 32'h00004000, 3'd2, 0, 0, 0, "out of range lw", got);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 9) == 0) ? (32'h2000 + $urandom_range(0, 255)) : $urandom_range(0, 255);
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
      wd = $urandom;
      if (kind == 0) begin
        if ($urandom_range(0, 5) != 0) a = a & ~32'h3;
        run_txn(1, 0, a, 3'd0, 0, 0, 0, "rand fetch", got);
      end else begin
        run_txn(0, kind == 2, a, f3, wd, 0, 0, (kind == 2) ? "rand store" : "rand load", got);
      end
    end

    check_eq("both ready cycles", both_ready_cycles, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Bus initiator for the unified 8 kB memory and its memory-mapped peripherals.
- Arbitrates the processor's instruction-fetch and load/store requests onto the single shared address bus.
- Sequences the memory's registered one-cycle read latency; the memory's instruction output is combinational.
- Extracts and sign/zero-extends sub-word load data, and flags misaligned or illegal accesses before any memory strobe.

Parameters:
- RESET_FUNCT3, 3'b010: funct3 driven while idle and for every fetch.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, level-held until if_ready
- if_pc  in  32  fetch address
- if_ready  out  1  fetch accepted this cycle
- d_req  in  1  load/store request, level-held until d_ready
- d_write  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_funct3  in  3  RV32I width/sign code
- d_wdata  in  32  store data, low-aligned
- d_ready  out  1  data request accepted this cycle
- rsp_valid  out  1  one-cycle response strobe
- rsp_is_fetch  out  1  response belongs to the fetch port
- rsp_data  out  32  instruction, or extended load data (0 for stores and errors)
- rsp_err  out  1  misaligned or illegal funct3
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- address  out  32  to memory
- write_data  out  32  to memory
- funct3  out  3  to memory
- read_data  in  32  from memory, full word, valid when mem_read is held
- instruction  in  32  from memory, combinational on address

Behaviour:
- States: IDLE, FETCH, LOAD_A, LOAD_B, STORE, RESP.
- Acceptance:
  - if_ready and d_ready are combinational and high only in IDLE.
  - Data has priority: d_ready = IDLE & d_req; if_ready = IDLE & if_req & ~d_req.
  - On acceptance, the request fields are registered. All bus outputs are driven from the registered fields and the state, never from requester inputs.
- IDLE: address=0, write_data=0, mem_read=0, mem_write=0, funct3=RESET_FUNCT3.
  - Data accepted: illegal funct3 goes to RESP with err; misaligned goes to RESP with err; store goes to STORE; load goes to LOAD_A.
  - Fetch accepted: if_pc[1:0]!=0 goes to RESP with err; otherwise FETCH.
- Legal data funct3: 000, 001, 010, 100, 101. Loads accept all five; stores accept 000, 001, 010 only.
- Alignment rules: word requires addr[1:0]==0; half requires addr[0]==0; byte is always legal.
- FETCH (1 cycle): address=pc_q, funct3=010, mem_read=0. Capture instruction at the edge, then RESP. Latency: accept edge to rsp_valid is 2 cycles.
- LOAD_A: address=addr_q, funct3=f3_q, mem_read=1. Go to LOAD_B.
- LOAD_B: same drive. At the edge, capture extract(read_data, addr_q[1:0], f3_q), then RESP. Latency is 3 cycles.
- STORE: address=addr_q, write_data=wdata_q, funct3=f3_q, mem_write=1 for exactly one cycle. The memory does its own lane placement. Then RESP; latency is 2 cycles.
- RESP: rsp_valid=1 for one cycle with the latched data, err and is_fetch, then IDLE. Responses are never back-pressured.
- Extraction rules:
  - lb/lbu: byte = word[8*a[1:0] +: 8], sign-extended or zero-extended.
  - lh/lhu: a[1] selects [31:16], else [15:0], sign-extended or zero-extended.
  - lw: the word unchanged.
- Error responses: rsp_data=0, no mem_read or mem_write pulse, latency 1 cycle.
- Out-of-range addresses are passed through; the memory returns 0. This is not an error.
- Simultaneous if_req and d_req in IDLE: data is served first. Fetch is accepted on the next IDLE cycle if still held.
- Reset:
  - State goes to IDLE; all outputs go to 0 except funct3=RESET_FUNCT3.
  - An in-flight transaction is dropped with no response.
  - mem_write drops asynchronously with rst, so there are no partial stores beyond the current edge.

Decomposition:
- Package mau_pkg:
  - state enum mau_state_t.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - functions is_legal_f3 and is_aligned.
- Sub-module load_align: combinational word/offset/funct3 to 32-bit extended result. It is instanced once and unit-testable alone.

Test Plan:
- Fetch at pc=0x10, mem[4]=0x00A00093: rsp_valid 2 cycles after accept, rsp_is_fetch=1, rsp_data=0x00A00093, mem_read never high.
- Load lb at 0x23 with mem[8]=0x80FF7F01: rsp_data=0xFFFFFF80. lbu gives 0x00000080. lh at 0x22 gives 0xFFFF80FF. lhu at 0x20 gives 0x00007F01. Each has mem_read high exactly 2 cycles and 3-cycle latency.
- Store sh 0xBEEF at 0x102: exactly one mem_write cycle with address=0x102, funct3=001, write_data=0x0000BEEF; a following lw 0x100 returns 0xBEEFxxxx.
- Misaligned lw at 0x101 and illegal store funct3=100: rsp_err=1, rsp_data=0, no mem_read/mem_write, 1-cycle latency.
- Simultaneous if_req and d_req: d_ready is high first; the fetch completes after the data response; no cycle has both ready signals high.
- Assert rst in LOAD_B and separately in STORE: outputs go to reset values immediately, no rsp_valid, the next request is served normally; the peripheral read at 0xFFFFFFF8 returns the millis value.
